conv_row_addr_sequencer: RTL and testbench
==========================================

# conv_row_addr_sequencer

Loop sequencer that drives the per-row address-translation controllers of the conv compute shell. Once per tile it walks the nested loop over row groups, kernel rows, row chunks and input-feature words. It presents one address tuple per beat (`iy_start`, `ky`, `row_start_idx`, `if_start`, `valid_adr`) under a valid/ready handshake. It signals tile completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `pixels_in_row`, default 32: pixels per buffer row chunk.
- `pixels_in_row_in_2pow`, default 5: log2(`pixels_in_row`).
- `ifs_in_row_2pow`, default 1: log2(input features per buffer word). Used only for `word_last`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: launch pulse. Sampled only in IDLE.
- `cfg_groups`, in, 16: number of output row groups.
- `cfg_iy_start`, in, 16: `iy_start` of group 0.
- `cfg_iy_step`, in, 16: `iy_start` increment per group.
- `cfg_k`, in, 16: kernel height (ky count).
- `cfg_nif_in_2pow`, in, 4: log2(input features).
- `cfg_ix_in_2pow`, in, 4: log2(input width).
- `ready`, in, 1: downstream accepts the current beat.
- `valid_adr`, out, 1: beat valid.
- `iy_start`, out, 16: current group's start row.
- `ky`, out, 16: current kernel row.
- `row_start_idx`, out, 16: chunk index × `pixels_in_row`.
- `if_start`, out, 16: 1-based input-feature index.
- `word_last`, out, 1: `if_start` is the last feature of its buffer word, i.e. `if_start[ifs_in_row_2pow-1:0]==0`. Forced to 1 when `ifs_in_row_2pow`=0.
- `last`, out, 1: current beat is the final beat of the tile.
- `busy`, out, 1: state ≠ IDLE.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: emits beats.
  - DONE: one cycle, `done`=1.
- Config is latched at `start` accepted in IDLE. Mid-tile changes to `cfg_*` have no effect.
- Derived counts, computed from latched config:
  - nif = 1<<`cfg_nif_in_2pow`.
  - chunks = 1<<(`cfg_ix_in_2pow`−`pixels_in_row_in_2pow`) if `cfg_ix_in_2pow` > `pixels_in_row_in_2pow`, else 1.
- Loop order, innermost first: `if_start` 1..nif, then chunk 0..chunks−1, then `ky` 0..`cfg_k`−1, then group 0..`cfg_groups`−1.
  - `row_start_idx` = chunk<<`pixels_in_row_in_2pow`.
  - `iy_start` = `cfg_iy_start` + group×`cfg_iy_step`, maintained as an accumulator. 16-bit, wraps modulo 2^16, no saturation.
- Counters advance only on acceptance (`valid_adr`&&`ready`). Each innermost wrap resets that counter and increments the next outer one.
- `last` = all four counters at their terminal values.
- Acceptance with `last`=1 moves the FSM to DONE. DONE moves to IDLE unconditionally.
- Start IDLE→RUN requires `cfg_groups`, `cfg_k` both nonzero. If either is zero, `start` goes IDLE→DONE directly with no beats emitted.
- `start` in RUN or DONE is ignored. There is no queueing.
- `reset` mid-tile: the next cycle is IDLE with all outputs at reset values. No `done` is issued.

## Timing
- Reset values: `valid_adr`=0, `iy_start`=0, `ky`=0, `row_start_idx`=0, `if_start`=0, `word_last`=0, `last`=0, `busy`=0, `done`=0.
- All outputs are registered.
- `start` at cycle c: `valid_adr`=1 with the first tuple at cycle c+1, with `busy`=1.
- Throughput is one beat per cycle while `ready`=1.
- With `ready`=0, the tuple and `valid_adr` hold stable. `valid_adr` never drops without acceptance.
- Final acceptance at cycle n:
  - cycle n+1: `valid_adr`=0, `done`=1, `busy`=1.
  - cycle n+2: `busy`=0, and a new `start` is accepted.
- Zero config: `start` at c gives `done`=1 at c+1 and IDLE at c+2.
- In IDLE and DONE, tuple outputs hold their last values and `valid_adr`=0.
- The downstream controller adds its own 1-cycle register. The sequencer does not compensate for it.

## Test plan
1. Basic tile. Config: `cfg_groups`=1, `cfg_k`=3, `cfg_nif_in_2pow`=1, `cfg_ix_in_2pow`=5, `ready`=1, `start` at cycle 0.
   - Beats 1–6 as (ky,row,if): (0,0,1),(0,0,2),(1,0,1),(1,0,2),(2,0,1),(2,0,2).
   - `last` set on beat 6; `done` at cycle 7; `busy`=0 at cycle 8.
2. Chunk and group nesting. Config: `cfg_groups`=2, `cfg_iy_start`=4, `cfg_iy_step`=2, `cfg_k`=1, `cfg_nif_in_2pow`=0, `cfg_ix_in_2pow`=6.
   - Beats as (iy,row): (4,0),(4,32),(6,0),(6,32).
   - `word_last`=1 on every beat.
3. Backpressure. Test 1 config with `ready`=0 for cycles 2–4.
   - Tuple (0,0,2) is held for 4 cycles.
   - Total 6 accepted beats; `done` at cycle 10.
4. Zero config. `cfg_k`=0, `start`: `done` at cycle 1, `valid_adr` never asserted. Repeat with `cfg_groups`=0: same result.
5. Reset and start rules.
   - Assert `reset` during beat 3 of test 1: next cycle all outputs at reset values, no `done`.
   - Fresh `start` afterwards replays from beat 1.
   - `start` pulsed during RUN is ignored: still exactly 6 beats.
6. Config isolation. Change `cfg_k` to 5 mid-tile of test 1: exactly 6 beats are still emitted.

Source files
------------

// File: rtl/conv_row_addr_sequencer.sv
// Per-tile nested-loop address sequencer for the conv row address controllers.
// Walks groups > ky > chunks > input features, one tuple per accepted beat.
module conv_row_addr_sequencer #(
   parameter int pixels_in_row         = 32,
   parameter int pixels_in_row_in_2pow = 5,
   parameter int ifs_in_row_2pow       = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] cfg_groups,
   input  logic [15:0] cfg_iy_start,
   input  logic [15:0] cfg_iy_step,
   input  logic [15:0] cfg_k,
   input  logic [3:0]  cfg_nif_in_2pow,
   input  logic [3:0]  cfg_ix_in_2pow,
   input  logic        ready,
   output logic        valid_adr,
   output logic [15:0] iy_start,
   output logic [15:0] ky,
   output logic [15:0] row_start_idx,
   output logic [15:0] if_start,
   output logic        word_last,
   output logic        last,
   output logic        busy,
   output logic        done,
   output logic [1:0]  dbg_state
);

   // Handshake: a beat transfers on a cycle where valid_adr && ready; while
   // valid_adr is high and ready is low, the tuple and valid_adr hold stable.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [15:0] WL_MASK  = (16'd1 << ifs_in_row_2pow) - 16'd1;
   localparam logic [15:0] ROW_STEP = 16'(pixels_in_row);

   state_t      state_q;
   logic [15:0] groups_m1_q, k_m1_q, nif_q, chunks_m1_q, step_q;
   logic [15:0] grp_q, chunk_q, ky_q, if_q, iy_q, row_q;
   logic        valid_q, wl_q, last_q, busy_q, done_q;

   logic [15:0] e_groups_m1, e_k_m1, e_nif, e_chunks_m1;
   logic [15:0] grp_d, chunk_d, ky_d, if_d, iy_d, row_d;
   logic        last_d, wl_d, accept;

   function automatic logic [15:0] chunks_m1_of(input logic [3:0] ix2);
      if (int'(ix2) > pixels_in_row_in_2pow)
         return (16'd1 << (int'(ix2) - pixels_in_row_in_2pow)) - 16'd1;
      else
         return 16'd0;
   endfunction

   assign accept = valid_q && ready;

   // In IDLE the loop bounds come straight from cfg so the first tuple's last
   // flag can be registered together with the start.
   always_comb begin
      e_groups_m1 = groups_m1_q;
      e_k_m1      = k_m1_q;
      e_nif       = nif_q;
      e_chunks_m1 = chunks_m1_q;
      grp_d       = grp_q;
      chunk_d     = chunk_q;
      ky_d        = ky_q;
      if_d        = if_q;
      iy_d        = iy_q;
      row_d       = row_q;
      if (state_q == S_IDLE) begin
         e_groups_m1 = cfg_groups - 16'd1;
         e_k_m1      = cfg_k - 16'd1;
         e_nif       = 16'd1 << cfg_nif_in_2pow;
         e_chunks_m1 = chunks_m1_of(cfg_ix_in_2pow);
         grp_d       = 16'd0;
         chunk_d     = 16'd0;
         ky_d        = 16'd0;
         if_d        = 16'd1;
         iy_d        = cfg_iy_start;
         row_d       = 16'd0;
      end else if (if_q != nif_q) begin
         if_d = if_q + 16'd1;
      end else begin
         if_d = 16'd1;
         if (chunk_q != chunks_m1_q) begin
            chunk_d = chunk_q + 16'd1;
            row_d   = row_q + ROW_STEP;
         end else begin
            chunk_d = 16'd0;
            row_d   = 16'd0;
            if (ky_q != k_m1_q) begin
               ky_d = ky_q + 16'd1;
            end else begin
               ky_d  = 16'd0;
               grp_d = grp_q + 16'd1;
               iy_d  = iy_q + step_q;
            end
         end
      end
      last_d = (if_d == e_nif) && (chunk_d == e_chunks_m1) &&
               (ky_d == e_k_m1) && (grp_d == e_groups_m1);
      wl_d   = ((if_d & WL_MASK) == 16'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         groups_m1_q <= 16'd0;
         k_m1_q      <= 16'd0;
         nif_q       <= 16'd0;
         chunks_m1_q <= 16'd0;
         step_q      <= 16'd0;
         grp_q       <= 16'd0;
         chunk_q     <= 16'd0;
         ky_q        <= 16'd0;
         if_q        <= 16'd0;
         iy_q        <= 16'd0;
         row_q       <= 16'd0;
         valid_q     <= 1'b0;
         wl_q        <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  groups_m1_q <= e_groups_m1;
                  k_m1_q      <= e_k_m1;
                  nif_q       <= e_nif;
                  chunks_m1_q <= e_chunks_m1;
                  step_q      <= cfg_iy_step;
                  busy_q      <= 1'b1;
                  if ((cfg_groups != 16'd0) && (cfg_k != 16'd0)) begin
                     state_q <= S_RUN;
                     valid_q <= 1'b1;
                     grp_q   <= grp_d;
                     chunk_q <= chunk_d;
                     ky_q    <= ky_d;
                     if_q    <= if_d;
                     iy_q    <= iy_d;
                     row_q   <= row_d;
                     wl_q    <= wl_d;
                     last_q  <= last_d;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (last_q) begin
                     state_q <= S_DONE;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     grp_q   <= grp_d;
                     chunk_q <= chunk_d;
                     ky_q    <= ky_d;
                     if_q    <= if_d;
                     iy_q    <= iy_d;
                     row_q   <= row_d;
                     wl_q    <= wl_d;
                     last_q  <= last_d;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign valid_adr     = valid_q;
   assign iy_start      = iy_q;
   assign ky            = ky_q;
   assign row_start_idx = row_q;
   assign if_start      = if_q;
   assign word_last     = wl_q;
   assign last          = last_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_conv_row_addr_sequencer.sv
// Bench for conv_row_addr_sequencer: scenario tasks plus a beat scoreboard
// fed by an independent nested-loop model of the tile.
module tb_conv_row_addr_sequencer;

   localparam int IFS = 1;
   localparam int PIX = 32;

   logic        clk = 1'b0;
   logic        reset, start, ready;
   logic [15:0] cfg_groups, cfg_iy_start, cfg_iy_step, cfg_k;
   logic [3:0]  cfg_nif_in_2pow, cfg_ix_in_2pow;
   logic        valid_adr, word_last, last, busy, done;
   logic [15:0] iy_start, ky, row_start_idx, if_start;
   logic [1:0]  dbg_state;
   logic        valid2, word_last2, last2, busy2, done2;
   logic [15:0] iy_start2, ky2, row_start_idx2, if_start2;
   logic [1:0]  dbg_state2;

   conv_row_addr_sequencer #(.pixels_in_row(PIX), .pixels_in_row_in_2pow(5),
                             .ifs_in_row_2pow(IFS)) dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_groups(cfg_groups), .cfg_iy_start(cfg_iy_start), .cfg_iy_step(cfg_iy_step),
      .cfg_k(cfg_k), .cfg_nif_in_2pow(cfg_nif_in_2pow), .cfg_ix_in_2pow(cfg_ix_in_2pow),
      .ready(ready), .valid_adr(valid_adr), .iy_start(iy_start), .ky(ky),
      .row_start_idx(row_start_idx), .if_start(if_start), .word_last(word_last),
      .last(last), .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   // One-feature-per-word variant: word_last must always read 1.
   conv_row_addr_sequencer #(.pixels_in_row(PIX), .pixels_in_row_in_2pow(5),
                             .ifs_in_row_2pow(0)) dut_w0 (
      .clk(clk), .reset(reset), .start(start),
      .cfg_groups(cfg_groups), .cfg_iy_start(cfg_iy_start), .cfg_iy_step(cfg_iy_step),
      .cfg_k(cfg_k), .cfg_nif_in_2pow(cfg_nif_in_2pow), .cfg_ix_in_2pow(cfg_ix_in_2pow),
      .ready(ready), .valid_adr(valid2), .iy_start(iy_start2), .ky(ky2),
      .row_start_idx(row_start_idx2), .if_start(if_start2), .word_last(word_last2),
      .last(last2), .busy(busy2), .done(done2), .dbg_state(dbg_state2)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int beat_cnt = 0;
   logic [65:0] exp_q[$];
   logic [65:0] got, want, held;
   logic        hold_pend = 1'b0;

   // Scoreboard: every accepted beat is popped and compared; stalled beats
   // must reappear unchanged on the next cycle.
   always @(negedge clk) begin
      got = {iy_start, ky, row_start_idx, if_start, word_last, last};
      if (reset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            n_vec++;
            if (!valid_adr || got !== held) begin
               n_err++;
               $display("FAIL hold: got valid=%0b tuple=%h, required valid=1 tuple=%h",
                        valid_adr, got, held);
            end
         end
         if (valid2) begin
            n_vec++;
            if (word_last2 !== 1'b1) begin
               n_err++;
               $display("FAIL word_last_w0: got %0b, required 1", word_last2);
            end
         end
         if (valid_adr && ready) begin
            beat_cnt++;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL beat: got unexpected tuple %h, required no beat", got);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  n_err++;
                  $display("FAIL beat: got iy=%0d ky=%0d row=%0d if=%0d wl=%0b last=%0b, required iy=%0d ky=%0d row=%0d if=%0d wl=%0b last=%0b",
                           got[65:50], got[49:34], got[33:18], got[17:2], got[1], got[0],
                           want[65:50], want[49:34], want[33:18], want[17:2], want[1], want[0]);
               end
            end
         end
         hold_pend = valid_adr && !ready;
         held      = got;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tile(input int groups, input int iy0, input int stp,
                            input int k, input int nif2, input int ix2);
      int nif, chunks;
      logic [15:0] iy;
      logic wl, lst;
      nif    = 1 << nif2;
      chunks = (ix2 > 5) ? (1 << (ix2 - 5)) : 1;
      iy     = 16'(iy0);
      for (int g = 0; g < groups; g++) begin
         for (int y = 0; y < k; y++)
            for (int c = 0; c < chunks; c++)
               for (int f = 1; f <= nif; f++) begin
                  lst = (g == groups - 1) && (y == k - 1) && (c == chunks - 1) && (f == nif);
                  wl  = ((f & ((1 << IFS) - 1)) == 0);
                  exp_q.push_back({iy, 16'(y), 16'(c * PIX), 16'(f), wl, lst});
               end
         iy = iy + 16'(stp);
      end
   endtask

   // Drives cfg + start in cycle 0 and returns positioned in cycle 1.
   task automatic start_tile(input int groups, input int iy0, input int stp,
                             input int k, input int nif2, input int ix2);
      cfg_groups      = 16'(groups);
      cfg_iy_start    = 16'(iy0);
      cfg_iy_step     = 16'(stp);
      cfg_k           = 16'(k);
      cfg_nif_in_2pow = 4'(nif2);
      cfg_ix_in_2pow  = 4'(ix2);
      ready           = 1'b1;
      start           = 1'b1;
      step();
      start           = 1'b0;
   endtask

   task automatic run_tile(input int spulse, input int kchg, output int done_cyc);
      done_cyc = -1;
      for (int cyc = 1; cyc < 60; cyc++) begin
         start = (cyc == spulse);
         if (cyc == kchg) cfg_k = 16'd5;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         step();
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_vec++;
      if ({valid_adr, iy_start, ky, row_start_idx, if_start, word_last, last, busy, done} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got valid=%0b iy=%0d ky=%0d row=%0d if=%0d busy=%0b done=%0b, required all 0",
                  valid_adr, iy_start, ky, row_start_idx, if_start, busy, done);
      end
      reset = 1'b0;
      step();
      n_vec++;
      if (busy !== 1'b0 || valid_adr !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_reset: got busy=%0b valid=%0b, required 0 0", busy, valid_adr);
      end
   endtask

   task automatic check_tile_end(input string name, input int dc, input int dc_exp,
                                 input int beats, input int beats_exp);
      n_vec++;
      if (dc != dc_exp) begin
         n_err++;
         $display("FAIL %s_done_cycle: got %0d, required %0d", name, dc, dc_exp);
      end
      n_vec++;
      if (beats != beats_exp || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_beats: got %0d (left %0d), required %0d (left 0)",
                  name, beats, exp_q.size(), beats_exp);
      end
      n_vec++;
      if (busy !== 1'b1 || valid_adr !== 1'b0) begin
         n_err++;
         $display("FAIL %s_done_state: got busy=%0b valid=%0b, required 1 0", name, busy, valid_adr);
      end
      step();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL %s_idle: got busy=%0b done=%0b, required 0 0", name, busy, done);
      end
   endtask

   task automatic test_basic();
      int dc, b0;
      b0 = beat_cnt;
      push_tile(1, 0, 0, 3, 1, 5);
      start_tile(1, 0, 0, 3, 1, 5);
      n_vec++;
      if (valid_adr !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_first_beat: got valid=%0b busy=%0b, required 1 1", valid_adr, busy);
      end
      run_tile(0, 0, dc);
      check_tile_end("basic", dc, 7, beat_cnt - b0, 6);
   endtask

   task automatic test_nesting();
      int dc, b0;
      b0 = beat_cnt;
      push_tile(2, 4, 2, 1, 0, 6);
      start_tile(2, 4, 2, 1, 0, 6);
      run_tile(0, 0, dc);
      check_tile_end("nesting", dc, 5, beat_cnt - b0, 4);
   endtask

   task automatic test_backpressure();
      int dc, b0;
      b0 = beat_cnt;
      dc = -1;
      push_tile(1, 0, 0, 3, 1, 5);
      start_tile(1, 0, 0, 3, 1, 5);
      for (int cyc = 1; cyc < 60; cyc++) begin
         ready = !(cyc >= 2 && cyc <= 4);
         if (cyc >= 2 && cyc <= 5) begin
            n_vec++;
            if (valid_adr !== 1'b1 || ky !== 16'd0 || if_start !== 16'd2) begin
               n_err++;
               $display("FAIL bp_hold_c%0d: got valid=%0b ky=%0d if=%0d, required 1 0 2",
                        cyc, valid_adr, ky, if_start);
            end
         end
         if (done) begin
            dc = cyc;
            break;
         end
         step();
      end
      ready = 1'b1;
      check_tile_end("backpressure", dc, 10, beat_cnt - b0, 6);
   endtask

   task automatic test_zero_cfg();
      int b0;
      for (int rep = 0; rep < 2; rep++) begin
         b0 = beat_cnt;
         start_tile(rep == 0 ? 1 : 0, 0, 0, rep == 0 ? 0 : 3, 1, 5);
         n_vec++;
         if (done !== 1'b1 || valid_adr !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL zero_cfg%0d_done: got done=%0b valid=%0b busy=%0b, required 1 0 1",
                     rep, done, valid_adr, busy);
         end
         step();
         n_vec++;
         if (busy !== 1'b0 || done !== 1'b0 || valid_adr !== 1'b0 || beat_cnt != b0) begin
            n_err++;
            $display("FAIL zero_cfg%0d_idle: got busy=%0b done=%0b valid=%0b beats=%0d, required 0 0 0 0",
                     rep, busy, done, valid_adr, beat_cnt - b0);
         end
      end
   endtask

   task automatic test_reset_mid();
      int dc, b0, seen_done;
      push_tile(1, 0, 0, 3, 1, 5);
      start_tile(1, 0, 0, 3, 1, 5);
      step();
      step();
      n_vec++;
      if (valid_adr !== 1'b1 || ky !== 16'd1 || if_start !== 16'd1) begin
         n_err++;
         $display("FAIL rst_mid_beat3: got valid=%0b ky=%0d if=%0d, required 1 1 1",
                  valid_adr, ky, if_start);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_q.delete();
      n_vec++;
      if ({valid_adr, iy_start, ky, row_start_idx, if_start, word_last, last, busy, done} !== '0) begin
         n_err++;
         $display("FAIL rst_mid_state: got valid=%0b ky=%0d if=%0d busy=%0b done=%0b, required all 0",
                  valid_adr, ky, if_start, busy, done);
      end
      seen_done = 0;
      for (int i = 0; i < 5; i++) begin
         if (done) seen_done++;
         step();
      end
      n_vec++;
      if (seen_done != 0) begin
         n_err++;
         $display("FAIL rst_mid_no_done: got %0d done pulses, required 0", seen_done);
      end
      b0 = beat_cnt;
      push_tile(1, 0, 0, 3, 1, 5);
      start_tile(1, 0, 0, 3, 1, 5);
      run_tile(0, 0, dc);
      check_tile_end("replay", dc, 7, beat_cnt - b0, 6);
   endtask

   task automatic test_start_ignored();
      int dc, b0;
      b0 = beat_cnt;
      push_tile(1, 0, 0, 3, 1, 5);
      start_tile(1, 0, 0, 3, 1, 5);
      run_tile(3, 0, dc);
      check_tile_end("start_in_run", dc, 7, beat_cnt - b0, 6);
   endtask

   task automatic test_cfg_isolation();
      int dc, b0;
      b0 = beat_cnt;
      push_tile(1, 0, 0, 3, 1, 5);
      start_tile(1, 0, 0, 3, 1, 5);
      run_tile(0, 2, dc);
      cfg_k = 16'd3;
      check_tile_end("cfg_iso", dc, 7, beat_cnt - b0, 6);
   endtask

   initial begin
      reset           = 1'b1;
      start           = 1'b0;
      ready           = 1'b1;
      cfg_groups      = 16'd0;
      cfg_iy_start    = 16'd0;
      cfg_iy_step     = 16'd0;
      cfg_k           = 16'd0;
      cfg_nif_in_2pow = 4'd0;
      cfg_ix_in_2pow  = 4'd0;
      #1;
      test_reset();
      test_basic();
      test_nesting();
      test_backpressure();
      test_zero_cfg();
      test_reset_mid();
      test_start_ignored();
      test_cfg_isolation();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
